// File: rtl/mul_div_unit_pkg.sv
// rtl/mul_div_unit_pkg.sv - shared op/state encodings and decode helpers for the multiply/divide unit
package mul_div_unit_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } mdu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2
    } mdu_state_e;

    // ALU SELECT[4:3] value that routes an instruction to this unit
    localparam logic [1:0] ALU_SEL_MDU = 2'b01;

    function automatic logic alu_sel_is_mdu(input logic [4:0] sel);
        return sel[4:3] == ALU_SEL_MDU;
    endfunction

    function automatic logic op_is_div(input logic [2:0] op);
        return op[2];
    endfunction

    function automatic logic op_is_rem(input logic [2:0] op);
        return op[2] & op[1];
    endfunction

    function automatic logic op_a_signed(input logic [2:0] op);
        return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic op_b_signed(input logic [2:0] op);
        return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    endfunction

endpackage

// File: rtl/mul_div_unit_if.sv
// rtl/mul_div_unit_if.sv - start/done request bus between the EX stage and the multiply/divide unit
interface mul_div_unit_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic [2:0]      op;
    logic [XLEN-1:0] data1;
    logic [XLEN-1:0] data2;
    logic            flush;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    modport master (
        output start, op, data1, data2, flush,
        input  busy, done, result
    );

    modport slave (
        input  start, op, data1, data2, flush,
        output busy, done, result
    );
endinterface

// File: rtl/mul_div_unit_div_step.sv
// rtl/mul_div_unit_div_step.sv - one combinational restoring-division step
module mul_div_unit_div_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rem_i,
    input  logic [XLEN-1:0] quot_i,
    input  logic [XLEN-1:0] divisor_i,
    output logic [XLEN-1:0] rem_o,
    output logic [XLEN-1:0] quot_o
);
    logic [XLEN:0] shifted;
    logic [XLEN:0] diff;

    always_comb begin
        shifted = {rem_i, quot_i[XLEN-1]};
        diff    = shifted - {1'b0, divisor_i};
        // diff MSB set means the trial subtraction borrowed: restore
        if (diff[XLEN]) begin
            rem_o  = shifted[XLEN-1:0];
            quot_o = {quot_i[XLEN-2:0], 1'b0};
        end else begin
            rem_o  = diff[XLEN-1:0];
            quot_o = {quot_i[XLEN-2:0], 1'b1};
        end
    end
endmodule

// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - iterative RV32M multiply/divide unit, one bit per cycle with sign fix-up
module mul_div_unit
    import mul_div_unit_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int EARLY_OUT = 1
) (
    input  logic          clk,
    input  logic          resetn,
    mul_div_unit_if.slave bus
);
    localparam int CW = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    mdu_state_e      state_q, state_d;
    mdu_op_e         op_q, op_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0] hi_q, hi_d, lo_q, lo_d, opb_q, opb_d, result_q, result_d;
    logic            neg_q, neg_d, done_q, done_d;

    logic            a_neg, b_neg, div_zero, div_ovf;
    logic [XLEN-1:0] a_mag, b_mag, step_rem, step_quot, rq_mag, rq_fix, fix_res;
    logic [XLEN:0]   mul_sum;
    logic [2*XLEN-1:0] prod_fix;

    // hi/lo hold the product during MUL*, remainder/quotient during DIV*
    mul_div_unit_div_step #(.XLEN(XLEN)) u_div_step (
        .rem_i    (hi_q),
        .quot_i   (lo_q),
        .divisor_i(opb_q),
        .rem_o    (step_rem),
        .quot_o   (step_quot)
    );

    always_comb begin
        a_neg    = op_a_signed(bus.op) & bus.data1[XLEN-1];
        b_neg    = op_b_signed(bus.op) & bus.data2[XLEN-1];
        a_mag    = a_neg ? -bus.data1 : bus.data1;
        b_mag    = b_neg ? -bus.data2 : bus.data2;
        div_zero = op_is_div(bus.op) & (bus.data2 == '0);
        div_ovf  = op_is_div(bus.op) & op_b_signed(bus.op) & (bus.data1 == MIN_NEG) & (&bus.data2);

        mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opb_q} : '0);
        prod_fix = neg_q ? -{hi_q, lo_q} : {hi_q, lo_q};
        rq_mag   = op_is_rem(op_q) ? hi_q : lo_q;
        rq_fix   = neg_q ? -rq_mag : rq_mag;
        if (op_is_div(op_q))
            fix_res = rq_fix;
        else if (op_q == OP_MUL)
            fix_res = prod_fix[XLEN-1:0];
        else
            fix_res = prod_fix[2*XLEN-1:XLEN];
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        opb_d    = opb_q;
        neg_d    = neg_q;
        result_d = result_q;
        done_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    op_d    = mdu_op_e'(bus.op);
                    cnt_d   = CW'(XLEN - 1);
                    state_d = ST_CALC;
                    if (op_is_div(bus.op)) begin
                        hi_d  = '0;
                        lo_d  = a_mag;
                        opb_d = b_mag;
                        // a zero divisor yields an all-ones quotient that must stay unsigned
                        neg_d = op_is_rem(bus.op) ? a_neg : ((a_neg ^ b_neg) & ~div_zero);
                        if ((EARLY_OUT != 0) && (div_zero || div_ovf)) begin
                            state_d = ST_FIX;
                            if (div_zero) begin
                                hi_d = a_mag;
                                lo_d = '1;
                            end
                        end
                    end else begin
                        hi_d  = '0;
                        lo_d  = b_mag;
                        opb_d = a_mag;
                        neg_d = a_neg ^ b_neg;
                    end
                end
            end
            ST_CALC: begin
                if (op_is_div(op_q)) begin
                    hi_d = step_rem;
                    lo_d = step_quot;
                end else begin
                    hi_d = mul_sum[XLEN:1];
                    lo_d = {mul_sum[0], lo_q[XLEN-1:1]};
                end
                if (cnt_q == '0) state_d = ST_FIX;
                else             cnt_d   = cnt_q - CW'(1);
            end
            ST_FIX: begin
                result_d = fix_res;
                done_d   = 1'b1;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        // flush wins over both a new start and a completing fix cycle
        if (bus.flush) begin
            state_d  = ST_IDLE;
            done_d   = 1'b0;
            result_d = result_q;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= ST_IDLE;
            op_q     <= OP_MUL;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            opb_q    <= '0;
            neg_q    <= 1'b0;
            result_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            opb_q    <= opb_d;
            neg_q    <= neg_d;
            result_q <= result_d;
            done_q   <= done_d;
        end
    end

    assign bus.busy   = (state_q != ST_IDLE);
    assign bus.done   = done_q;
    assign bus.result = result_q;
endmodule

// File: tb/tb_mul_div_unit.sv
// tb/tb_mul_div_unit.sv - scoreboard bench for mul_div_unit with directed RV32M vectors
module tb_mul_div_unit;
    logic clk = 1'b0;
    logic resetn = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    logic [31:0] last_exp = '0;

    typedef struct {
        logic [31:0] res;
        int          cyc;
        string       name;
    } exp_t;
    exp_t sb[$];

    mul_div_unit_if #(.XLEN(32)) bus ();

    mul_div_unit #(.XLEN(32), .EARLY_OUT(1)) dut (
        .clk   (clk),
        .resetn(resetn),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (resetn && bus.done) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_done: got done=1 result 0x%08h expected no done", bus.result);
            end else begin
                e = sb.pop_front();
                check(e.name, bus.result, e.res);
                check({e.name, "_cycle"}, cyc, e.cyc);
                check({e.name, "_busy"}, {31'b0, bus.busy}, 32'd0);
            end
        end
    end

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input int lat, input string name, input bit push);
        int n = 0;
        @(negedge clk);
        while (bus.busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (bus.busy) begin
            checks++;
            errors++;
            $display("FAIL %s_wait: got busy=1 expected busy=0 within 200 cycles", name);
        end
        bus.start = 1'b1;
        bus.op    = op;
        bus.data1 = a;
        bus.data2 = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.data1 = 32'hDEAD_BEEF;
        bus.data2 = 32'h1234_5678;
        bus.op    = 3'b101;
        if (push) begin
            sb.push_back('{exp, cyc + lat, name});
            last_exp = exp;
        end
        check({name, "_accept_busy"}, {31'b0, bus.busy}, 32'd1);
    endtask

    initial begin
        int n;
        bus.start = 1'b0;
        bus.flush = 1'b0;
        bus.op    = 3'b000;
        bus.data1 = '0;
        bus.data2 = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", {31'b0, bus.busy}, 32'd0);
        check("reset_done", {31'b0, bus.done}, 32'd0);
        check("reset_result", bus.result, 32'd0);
        @(negedge clk);
        resetn = 1'b1;

        issue(3'b000, 32'd5, 32'd2, 32'd10, 33, "mul_5x2", 1);
        issue(3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33, "mulh_min", 1);
        issue(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, "mulhu_max", 1);
        issue(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, "mulhsu_max", 1);
        issue(3'b000, 32'hFFFF_FFFF, 32'd3, 32'hFFFF_FFFD, 33, "mul_neg3", 1);
        issue(3'b011, 32'h8000_0000, 32'd2, 32'd1, 33, "mulhu_carry", 1);
        issue(3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, "div_m7_2", 1);
        issue(3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, "rem_m7_2", 1);
        issue(3'b101, 32'd7, 32'd2, 32'd3, 33, "divu_7_2", 1);
        issue(3'b111, 32'd5, 32'd2, 32'd1, 33, "remu_5_2", 1);
        issue(3'b100, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 33, "div_100_m7", 1);
        issue(3'b110, 32'd100, 32'hFFFF_FFF9, 32'd2, 33, "rem_100_m7", 1);
        issue(3'b100, 32'h8000_0000, 32'd2, 32'hC000_0000, 33, "div_min_2", 1);
        issue(3'b100, 32'd7, 32'd0, 32'hFFFF_FFFF, 1, "div_by0", 1);
        issue(3'b110, 32'd7, 32'd0, 32'd7, 1, "rem_by0", 1);
        issue(3'b101, 32'd7, 32'd0, 32'hFFFF_FFFF, 1, "divu_by0", 1);
        issue(3'b111, 32'hFFFF_FFF0, 32'd0, 32'hFFFF_FFF0, 1, "remu_by0", 1);
        issue(3'b100, 32'hFFFF_FFF8, 32'd0, 32'hFFFF_FFFF, 1, "div_neg_by0", 1);
        issue(3'b110, 32'hFFFF_FFF8, 32'd0, 32'hFFFF_FFF8, 1, "rem_neg_by0", 1);
        issue(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, "div_ovf", 1);
        issue(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, "rem_ovf", 1);

        // flush in cycle 10 of a divide: no done, result keeps the previous value
        issue(3'b100, 32'd100, 32'd7, 32'd0, 33, "div_flushed", 0);
        repeat (9) @(posedge clk);
        #1;
        bus.flush = 1'b1;
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        check("flush_busy", {31'b0, bus.busy}, 32'd0);
        check("flush_result", bus.result, last_exp);
        issue(3'b101, 32'd9, 32'd3, 32'd3, 33, "divu_after_flush", 1);

        // flush together with start in idle: start is dropped
        @(negedge clk);
        while (bus.busy) @(negedge clk);
        @(posedge clk);
        #1;
        bus.flush = 1'b1;
        bus.start = 1'b1;
        bus.op    = 3'b100;
        bus.data1 = 32'd7;
        bus.data2 = 32'd0;
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        bus.start = 1'b0;
        check("flush_start_busy", {31'b0, bus.busy}, 32'd0);

        // start while busy is ignored
        issue(3'b000, 32'd6, 32'd7, 32'd42, 33, "mul_6x7", 1);
        repeat (3) @(posedge clk);
        #1;
        bus.start = 1'b1;
        bus.op    = 3'b100;
        bus.data1 = 32'd7;
        bus.data2 = 32'd0;
        @(posedge clk);
        #1;
        bus.start = 1'b0;

        // reset in the middle of a multiply clears everything asynchronously
        issue(3'b000, 32'd3, 32'd3, 32'd9, 33, "mul_reset", 1);
        repeat (5) @(posedge clk);
        #2;
        resetn = 1'b0;
        #1;
        check("async_rst_busy", {31'b0, bus.busy}, 32'd0);
        check("async_rst_done", {31'b0, bus.done}, 32'd0);
        check("async_rst_result", bus.result, 32'd0);
        sb.delete();
        last_exp = '0;
        @(negedge clk);
        resetn = 1'b1;

        issue(3'b011, 32'd4, 32'd5, 32'd0, 33, "mulhu_small", 1);
        issue(3'b000, 32'd4, 32'd5, 32'd20, 33, "mul_b2b", 1);

        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d pending results expected 0", sb.size());
        end
        repeat (4) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
